sram_writer: RTL and testbench

SRAM_WRITER -- requirements
Module: sram_writer

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_writer.sv | 159 +++++++++++++++
 tb/tb_sram_writer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM write path.
// Holds the FSM state type, default address/data widths and the idle levels
// of the active-low strobes and the pad output enable. The SRAM controller
// reuses these definitions.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  // Idle level of the active-low strobes (CE_n/OE_n/WE_n/UB_n/LB_n)
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;
  // Idle level of the pad output enable
  localparam logic PAD_OFF    = 1'b0;
  localparam logic PAD_ON     = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } sram_state_t;

endpackage

// File: rtl/sram_writer.sv
// sram_writer: writes a burst of words from a valid/ready source into an
// asynchronous SRAM, one WE_n-controlled write cycle per word.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start                 pulse in IDLE: latch base_addr and num_words
//   base_addr, num_words  first word address and word count of the job
//   abort                 level: finish the in-flight word, then end the job
//   wr_valid, wr_data,    source word and byte enables (bit1 upper byte,
//   wr_be                 bit0 lower byte)
//   wr_ready              word accepted when wr_valid && wr_ready
//   addr, dq_out, dq_oe   SRAM address, pad data and pad output enable
//   CE_n, OE_n, WE_n,     active-low SRAM strobes (OE_n is held inactive)
//   UB_n, LB_n
//   busy                  job in progress (WAIT through HOLD)
//   done                  one-cycle pulse at job end
//
// Per word: WAIT (1) + SETUP (1) + PULSE (WE_CYCLES) + HOLD (1) cycles.
// Every output is a register updated on the edge that enters the state it
// belongs to, so the whole FSM lives in one always_ff.
module sram_writer #(
  parameter int unsigned ADDR_W    = sram_pkg::SRAM_ADDR_W,
  parameter int unsigned DATA_W    = sram_pkg::SRAM_DATA_W,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              CE_n,
  output logic              OE_n,
  output logic              WE_n,
  output logic              UB_n,
  output logic              LB_n,
  output logic              busy,
  output logic              done
);
  import sram_pkg::*;

  localparam logic [3:0] PULSE_LAST = 4'(WE_CYCLES - 1);

  sram_state_t       state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] job_words;
  logic [ADDR_W-1:0] words_written;
  logic [3:0]        pulse_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      job_words     <= '0;
      words_written <= '0;
      pulse_cnt     <= '0;
      addr          <= '0;
      dq_out        <= '0;
      dq_oe         <= PAD_OFF;
      CE_n          <= STROBE_OFF;
      OE_n          <= STROBE_OFF;
      WE_n          <= STROBE_OFF;
      UB_n          <= STROBE_OFF;
      LB_n          <= STROBE_OFF;
      wr_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      OE_n <= STROBE_OFF;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr      <= base_addr;
            job_words     <= num_words;
            words_written <= '0;
            if (num_words != '0) begin
              state    <= S_WAIT;
              wr_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          // abort wins over a waiting word: nothing is in flight yet
          if (abort) begin
            state    <= S_DONE;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (wr_valid) begin
            // dq_out/UB_n/LB_n double as the latch for the accepted word
            state    <= S_SETUP;
            wr_ready <= 1'b0;
            addr     <= cur_addr;
            dq_out   <= wr_data;
            dq_oe    <= PAD_ON;
            CE_n     <= STROBE_ON;
            UB_n     <= ~wr_be[1];
            LB_n     <= ~wr_be[0];
          end
        end

        S_SETUP: begin
          state     <= S_PULSE;
          WE_n      <= STROBE_ON;
          pulse_cnt <= PULSE_LAST;
        end

        S_PULSE: begin
          if (pulse_cnt == 4'd0) begin
            state <= S_HOLD;
            WE_n  <= STROBE_OFF;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end

        S_HOLD: begin
          cur_addr      <= cur_addr + ADDR_W'(1);
          words_written <= words_written + ADDR_W'(1);
          dq_oe         <= PAD_OFF;
          CE_n          <= STROBE_OFF;
          UB_n          <= STROBE_OFF;
          LB_n          <= STROBE_OFF;
          // compare against the post-increment count
          if (((words_written + ADDR_W'(1)) == job_words) || abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wr_ready <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_writer.sv
module tb_sram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // default-parameter instance
  logic        start = 1'b0;
  logic [19:0] base_addr = '0;
  logic [19:0] num_words = '0;
  logic        abort = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        wr_ready;
  logic [19:0] addr;
  logic [15:0] dq_out;
  logic        dq_oe, CE_n, OE_n, WE_n, UB_n, LB_n, busy, done;

  // WE_CYCLES=3 instance
  logic        start3 = 1'b0;
  logic [19:0] base3 = '0;
  logic [19:0] num3 = '0;
  logic        abort3 = 1'b0;
  logic        valid3 = 1'b0;
  logic [15:0] data3 = '0;
  logic [1:0]  be3 = '0;
  logic        ready3;
  logic [19:0] addr3;
  logic [15:0] dq_out3;
  logic        dq_oe3, CE_n3, OE_n3, WE_n3, UB_n3, LB_n3, busy3, done3;

  sram_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .abort(abort), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready), .addr(addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
    .UB_n(UB_n), .LB_n(LB_n), .busy(busy), .done(done)
  );

  sram_writer #(.WE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base3),
    .num_words(num3), .abort(abort3), .wr_valid(valid3),
    .wr_data(data3), .wr_be(be3), .wr_ready(ready3), .addr(addr3),
    .dq_out(dq_out3), .dq_oe(dq_oe3), .CE_n(CE_n3), .OE_n(OE_n3), .WE_n(WE_n3),
    .UB_n(UB_n3), .LB_n(LB_n3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor for the default instance: one record per WE_n falling edge
  int          n_busy = 0;
  int          n_done = 0;
  int          n_we_low = 0;
  logic        prev_we = 1'b1;
  logic [19:0] wa[$];
  logic [15:0] wd[$];
  logic [1:0]  wul[$];
  logic [1:0]  wce[$];

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (done) n_done++;
    if (!WE_n) begin
      n_we_low++;
      if (prev_we) begin
        wa.push_back(addr);
        wd.push_back(dq_out);
        wul.push_back({UB_n, LB_n});
        wce.push_back({CE_n, dq_oe});
      end
    end
    prev_we = WE_n;
  end

  // Monitor for the WE_CYCLES=3 instance (single job: 0x40 <- 0x5A5A)
  int n_we3 = 0, n_ce3 = 0, bad3 = 0, n_busy3 = 0, n_done3 = 0;

  always @(negedge clk) begin
    if (!WE_n3) n_we3++;
    if (!CE_n3) begin
      n_ce3++;
      if (addr3 !== 20'h00040 || dq_out3 !== 16'h5A5A || !dq_oe3 || UB_n3 || LB_n3) bad3++;
    end
    if (busy3) n_busy3++;
    if (done3) n_done3++;
  end

  logic [15:0] src_d[8];
  logic [1:0]  src_be[8];

  task automatic run_job(input logic [19:0] base, input logic [19:0] num,
                         input int abort_at, input logic abort_init,
                         input int restart_at, output int cycles_to_done);
    int idx;
    int cyc;
    bit acc;
    bit seen;
    idx = 0;
    cyc = 0;
    seen = 0;
    @(negedge clk);
    base_addr = base;
    num_words = num;
    abort = abort_init;
    wr_valid = 1'b1;
    while (!seen && cyc < 200) begin
      start = (cyc == 0);
      if (restart_at > 0 && idx == restart_at) begin
        start = 1'b1;
        base_addr = 20'h00055;
        num_words = 20'd9;
      end
      wr_data = src_d[idx % 8];
      wr_be = src_be[idx % 8];
      acc = wr_ready && wr_valid;
      if (abort_at > 0 && idx == abort_at && !WE_n) abort = 1'b1;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      if (done) seen = 1;
    end
    start = 1'b0;
    abort = 1'b0;
    wr_valid = 1'b0;
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
    cycles_to_done = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, b0, d0, l0, cyc;

    repeat (3) @(negedge clk);
    check("rst_strobes", 32'({CE_n, OE_n, WE_n, UB_n, LB_n, dq_oe, busy, done, wr_ready}), 32'h1F0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_dq", 32'(dq_out), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // WE_CYCLES=3: one word
    start3 = 1'b1; base3 = 20'h00040; num3 = 20'd1; valid3 = 1'b1;
    data3 = 16'h5A5A; be3 = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (done3) break;
    end
    valid3 = 1'b0;
    repeat (3) @(negedge clk);
    check("w3_we_low", 32'(n_we3), 32'd3);
    check("w3_ce_low", 32'(n_ce3), 32'd5);
    check("w3_stable", 32'(bad3), 32'd0);
    check("w3_busy", 32'(n_busy3), 32'd6);
    check("w3_done", 32'(n_done3), 32'd1);

    // Three-word burst, valid held
    src_d[0] = 16'hA5A5; src_d[1] = 16'h1234; src_d[2] = 16'hBEEF;
    src_be[0] = 2'b11; src_be[1] = 2'b11; src_be[2] = 2'b11;
    w0 = wa.size(); b0 = n_busy; d0 = n_done; l0 = n_we_low;
    run_job(20'h00010, 20'd3, 0, 1'b0, 0, cyc);
    repeat (3) @(negedge clk);
    check("b3_latency", 32'(cyc), 32'd13);
    check("b3_writes", 32'(wa.size() - w0), 32'd3);
    if (wa.size() - w0 == 3) begin
      check("b3_a0", 32'(wa[w0]), 32'h10);
      check("b3_a1", 32'(wa[w0+1]), 32'h11);
      check("b3_a2", 32'(wa[w0+2]), 32'h12);
      check("b3_d0", 32'(wd[w0]), 32'hA5A5);
      check("b3_d1", 32'(wd[w0+1]), 32'h1234);
      check("b3_d2", 32'(wd[w0+2]), 32'hBEEF);
      check("b3_bytes", 32'(wul[w0+1]), 32'h0);
      check("b3_ce_oe", 32'(wce[w0+2]), 32'h1);
    end
    check("b3_busy", 32'(n_busy - b0), 32'd12);
    check("b3_done", 32'(n_done - d0), 32'd1);
    check("b3_we_low", 32'(n_we_low - l0), 32'd3);
    check("oe_n_high", 32'(OE_n), 32'h1);

    // Zero-length job
    w0 = wa.size(); b0 = n_busy; d0 = n_done;
    run_job(20'h00020, 20'd0, 0, 1'b0, 0, cyc);
    repeat (3) @(negedge clk);
    check("z_latency", 32'(cyc), 32'd1);
    check("z_writes", 32'(wa.size() - w0), 32'd0);
    check("z_busy", 32'(n_busy - b0), 32'd0);
    check("z_done", 32'(n_done - d0), 32'd1);

    // Address wrap, mixed byte enables, start while busy ignored
    src_d[0] = 16'h1111; src_d[1] = 16'h2222; src_d[2] = 16'h3333;
    src_be[0] = 2'b01; src_be[1] = 2'b10; src_be[2] = 2'b00;
    w0 = wa.size(); d0 = n_done;
    run_job(20'hFFFFE, 20'd3, 0, 1'b0, 1, cyc);
    repeat (3) @(negedge clk);
    check("wr_writes", 32'(wa.size() - w0), 32'd3);
    if (wa.size() - w0 == 3) begin
      check("wr_a0", 32'(wa[w0]), 32'hFFFFE);
      check("wr_a1", 32'(wa[w0+1]), 32'hFFFFF);
      check("wr_a2", 32'(wa[w0+2]), 32'h00000);
      check("wr_d1", 32'(wd[w0+1]), 32'h2222);
      check("wr_be01", 32'(wul[w0]), 32'h2);
      check("wr_be10", 32'(wul[w0+1]), 32'h1);
      check("wr_be00", 32'(wul[w0+2]), 32'h3);
    end
    check("wr_done", 32'(n_done - d0), 32'd1);

    // Abort already high in WAIT
    w0 = wa.size(); b0 = n_busy; d0 = n_done;
    run_job(20'h00400, 20'd4, 0, 1'b1, 0, cyc);
    repeat (3) @(negedge clk);
    check("aw_latency", 32'(cyc), 32'd2);
    check("aw_writes", 32'(wa.size() - w0), 32'd0);
    check("aw_busy", 32'(n_busy - b0), 32'd1);
    check("aw_done", 32'(n_done - d0), 32'd1);

    // Abort during PULSE of word 2 of 5
    src_be[0] = 2'b11; src_be[1] = 2'b11; src_be[2] = 2'b11;
    w0 = wa.size(); d0 = n_done;
    run_job(20'h00500, 20'd5, 2, 1'b0, 0, cyc);
    repeat (3) @(negedge clk);
    check("ap_writes", 32'(wa.size() - w0), 32'd2);
    if (wa.size() - w0 == 2) check("ap_a1", 32'(wa[w0+1]), 32'h501);
    check("ap_done", 32'(n_done - d0), 32'd1);

    // Abort coincident with the last word
    w0 = wa.size(); d0 = n_done;
    run_job(20'h00600, 20'd2, 2, 1'b0, 0, cyc);
    repeat (4) @(negedge clk);
    check("al_latency", 32'(cyc), 32'd9);
    check("al_writes", 32'(wa.size() - w0), 32'd2);
    check("al_done", 32'(n_done - d0), 32'd1);

    // Reset in the middle of PULSE
    d0 = n_done;
    @(negedge clk);
    base_addr = 20'h00200; num_words = 20'd3; start = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h7777; wr_be = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!WE_n) break;
    end
    check("rp_in_pulse", 32'(WE_n), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rp_strobes", 32'({CE_n, OE_n, WE_n, UB_n, LB_n, dq_oe, busy, done, wr_ready}), 32'h1F0);
    check("rp_addr", 32'(addr), 32'h0);
    rst = 1'b0;
    wr_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rp_no_done", 32'(n_done - d0), 32'd0);

    // Normal job after reset
    src_d[0] = 16'hC0DE;
    w0 = wa.size(); d0 = n_done;
    run_job(20'h00300, 20'd1, 0, 1'b0, 0, cyc);
    repeat (3) @(negedge clk);
    check("ra_writes", 32'(wa.size() - w0), 32'd1);
    if (wa.size() - w0 == 1) begin
      check("ra_addr", 32'(wa[w0]), 32'h300);
      check("ra_data", 32'(wd[w0]), 32'hC0DE);
    end
    check("ra_done", 32'(n_done - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
